lane_polarity_corrector: RTL and testbench

- Receive-side counterpart to the per-lane polarity inverter (buffer/inverter gate array) used on the transmit side of a multi-lane serial link.
- Each lane arrives as one bit per valid beat, and the transmitter may have inverted any lane.
- The block learns the per-lane inversion mask from a known training pattern, then XOR-corrects all subsequent traffic.
- Sits between the lane deserialiser and the link-layer framer.

---
 rtl/lane_polarity_corrector_pkg.sv | 13 +
 rtl/lane_pattern_matcher.sv | 36 +++
 rtl/lane_polarity_corrector.sv | 165 ++++++++++++++++
 tb/tb_lane_polarity_corrector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_polarity_corrector_pkg.sv
// Shared lane-polarity definitions: FSM state encodings and the default training word.
// Used by both the transmit inverter and the receive corrector.
package lane_polarity_corrector_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRAIN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    localparam int         DEF_TRAIN_LEN     = 8;
    localparam logic [7:0] DEF_TRAIN_PATTERN = 8'b1011_0010;

endpackage

// File: rtl/lane_pattern_matcher.sv
// One lane's training window: LSB-in shift register plus match/polarity flags
// computed on the window that includes the current bit.
module lane_pattern_matcher
    import lane_polarity_corrector_pkg::*;
#(
    parameter int                   TRAIN_LEN     = DEF_TRAIN_LEN,
    parameter logic [TRAIN_LEN-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic shift_i,
    input  logic bit_i,
    output logic match_o,
    output logic pol_o
);

    logic [TRAIN_LEN-1:0] sr_q, sr_d, win;

    assign win = {sr_q[TRAIN_LEN-2:0], bit_i};

    always_comb begin
        sr_d = sr_q;
        if (clr_i)        sr_d = '0;
        else if (shift_i) sr_d = win;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    assign pol_o   = (win == ~TRAIN_PATTERN);
    assign match_o = (win == TRAIN_PATTERN) || pol_o;

endmodule

// File: rtl/lane_polarity_corrector.sv
// Receive-side lane polarity corrector: learns the per-lane inversion mask from
// a training pattern, then XOR-corrects traffic. Optional LANE_POL_FORCE_EN adds a mask override.
module lane_polarity_corrector
    import lane_polarity_corrector_pkg::*;
#(
    parameter int                   LANES         = 4,
    parameter int                   TRAIN_LEN     = DEF_TRAIN_LEN,
    parameter logic [TRAIN_LEN-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int                   LOCK_COUNT    = 2,
    parameter int                   MAX_WINDOWS   = 8,
    parameter logic [LANES-1:0]     DEFAULT_MASK  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             train_start,
`ifdef LANE_POL_FORCE_EN
    input  logic             force_en,
    input  logic [LANES-1:0] force_mask,
`endif
    input  logic [LANES-1:0] in_data,
    input  logic             in_valid,
    output logic [LANES-1:0] out_data,
    output logic             out_valid,
    output logic [LANES-1:0] pol_mask,
    output logic             locked,
    output logic             train_err
);

    localparam int                BEAT_W    = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TRAIN_LEN - 1);
    localparam logic [7:0]        MAXW      = 8'(MAX_WINDOWS);
    localparam logic [3:0]        LOCKC     = 4'(LOCK_COUNT);

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [7:0]        win_cnt_q, win_cnt_d;
    logic [3:0]        match_cnt_q, match_cnt_d;
    logic [LANES-1:0]  cand_q, cand_d;
    logic [LANES-1:0]  pol_mask_q, pol_mask_d;
    logic [LANES-1:0]  out_data_q;
    logic              out_valid_q;

    logic [LANES-1:0]  lane_match, lane_pol;
    logic              force_hit, restart, in_train, shift, eval, lock_hit, err_hit;

`ifdef LANE_POL_FORCE_EN
    assign force_hit = force_en;
`else
    assign force_hit = 1'b0;
`endif

    assign restart  = train_start && !force_hit;
    assign in_train = (state_q == ST_TRAIN);
    assign shift    = in_train && in_valid && !train_start && !force_hit;
    assign eval     = shift && (beat_cnt_q == LAST_BEAT);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_pattern_matcher #(
            .TRAIN_LEN     (TRAIN_LEN),
            .TRAIN_PATTERN (TRAIN_PATTERN)
        ) u_match (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (restart),
            .shift_i (shift),
            .bit_i   (in_data[g]),
            .match_o (lane_match[g]),
            .pol_o   (lane_pol[g])
        );
    end

    // Window bookkeeping; a zero run count means "no previous mask to agree with".
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        win_cnt_d   = win_cnt_q;
        match_cnt_d = match_cnt_q;
        cand_d      = cand_q;
        if (restart) begin
            beat_cnt_d  = '0;
            win_cnt_d   = '0;
            match_cnt_d = '0;
            cand_d      = '0;
        end else if (shift) begin
            beat_cnt_d = eval ? '0 : beat_cnt_q + 1'b1;
            if (eval) begin
                win_cnt_d = win_cnt_q + 8'd1;
                if (&lane_match) begin
                    cand_d      = lane_pol;
                    match_cnt_d = (match_cnt_q == 4'd0 || lane_pol == cand_q) ?
                                  match_cnt_q + 4'd1 : 4'd1;
                end else begin
                    match_cnt_d = '0;
                end
            end
        end
    end

    assign lock_hit = eval && (match_cnt_d == LOCKC);
    assign err_hit  = eval && !lock_hit && (win_cnt_d == MAXW);

    always_comb begin
        pol_mask_d = pol_mask_q;
`ifdef LANE_POL_FORCE_EN
        if (force_en)      pol_mask_d = force_mask;
        else if (lock_hit) pol_mask_d = lane_pol;
`else
        if (lock_hit)      pol_mask_d = lane_pol;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            win_cnt_q   <= '0;
            match_cnt_q <= '0;
            cand_q      <= '0;
            pol_mask_q  <= DEFAULT_MASK;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            win_cnt_q   <= win_cnt_d;
            match_cnt_q <= match_cnt_d;
            cand_q      <= cand_d;
            pol_mask_q  <= pol_mask_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (force_hit)        state_d = ST_LOCKED;
        else if (train_start) state_d = ST_TRAIN;
        else if (in_train) begin
            if (lock_hit)     state_d = ST_LOCKED;
            else if (err_hit) state_d = ST_ERROR;
        end
    end

    // FSM: outputs
    always_comb begin
        locked    = (state_q == ST_LOCKED);
        train_err = (state_q == ST_ERROR);
    end

    // Output register uses the mask as it stood before any same-edge update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (in_valid) out_data_q <= in_data ^ pol_mask_q;
            out_valid_q <= in_valid && (state_q == ST_IDLE || state_q == ST_LOCKED);
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign pol_mask  = pol_mask_q;

endmodule

// File: tb/tb_lane_polarity_corrector.sv
// Bench for lane_polarity_corrector: vector table, hand sequences and a random run
// checked every cycle against a window-queue reference model.
module tb_lane_polarity_corrector;

    localparam int TLEN = 8;
    localparam int LOCK = 2;
    localparam int MAXW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       train_start = 1'b0;
    logic       force_en = 1'b0;
    logic [3:0] force_mask = 4'b0;
    logic [3:0] in_data = 4'b0;
    logic       in_valid = 1'b0;
    logic [3:0] out_data, pol_mask;
    logic       out_valid, locked, train_err;

    int total = 0;
    int bad = 0;
    logic [7:0] pat = 8'b1011_0010;

    always #5 clk = ~clk;

    lane_polarity_corrector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .train_start (train_start),
`ifdef LANE_POL_FORCE_EN
        .force_en    (force_en),
        .force_mask  (force_mask),
`endif
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .pol_mask    (pol_mask),
        .locked      (locked),
        .train_err   (train_err)
    );

    // Reference model: 0=idle 1=train 2=locked 3=error
    int         m_state, m_wins, m_run;
    logic [3:0] m_mask, m_od, m_prev;
    logic       m_ov;
    logic [3:0] m_q[$];

    task automatic model_step(input logic rst, ts, fe, input logic [3:0] fm,
                              input logic iv, input logic [3:0] d);
        logic [3:0] pol;
        bit         all_ok;
        if (!rst) begin
            m_state = 0; m_mask = 4'b0; m_od = 4'b0; m_ov = 1'b0;
            m_wins = 0; m_run = 0; m_prev = 4'b0; m_q.delete();
            return;
        end
        if (iv) m_od = d ^ m_mask;
        m_ov = iv && (m_state == 0 || m_state == 2);
        if (fe) begin
            m_mask = fm; m_state = 2;
        end else if (ts) begin
            m_state = 1; m_q.delete(); m_wins = 0; m_run = 0;
        end else if (m_state == 1 && iv) begin
            m_q.push_back(d);
            if (m_q.size() == TLEN) begin
                all_ok = 1;
                for (int l = 0; l < 4; l++) begin
                    int word = 0;
                    for (int k = 0; k < TLEN; k++) word = word * 2 + int'(m_q[k][l]);
                    pol[l] = (word == (255 - int'(pat)));
                    if (word != int'(pat) && !pol[l]) all_ok = 0;
                end
                if (!all_ok)                         m_run = 0;
                else if (m_run == 0 || pol == m_prev) m_run++;
                else                                  m_run = 1;
                if (all_ok) m_prev = pol;
                m_wins++;
                m_q.delete();
                if (m_run == LOCK) begin
                    m_state = 2; m_mask = pol;
                end else if (m_wins == MAXW) m_state = 3;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(rst_n, train_start, force_en, force_mask, in_valid, in_data);
        #1;
        chk("model", {21'b0, out_data, out_valid, pol_mask, locked, train_err},
                     {21'b0, m_od, m_ov, m_mask, m_state == 2, m_state == 3});
    endtask

    task automatic do_reset();
        rst_n = 1'b0; train_start = 1'b0; in_valid = 1'b0; force_en = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic start_train();
        train_start = 1'b1; in_valid = 1'b0;
        step();
        train_start = 1'b0;
    endtask

    task automatic beat(input int b, input logic [3:0] mask);
        logic bt;
        bt = pat[7 - (b % 8)];
        in_valid = 1'b1;
        in_data = {4{bt}} ^ mask;
        step();
    endtask

    typedef struct {
        string      name;
        logic [3:0] m1, m2, m3;
        bit         l2ff, gap;
        int         beats;
        bit         e_lock, e_err;
        logic [3:0] e_mask;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{"m1010",  4'b1010, 4'b1010, 4'b1010, 0, 0, 16, 1, 0, 4'b1010};
        tbl[1] = '{"m0000",  4'b0000, 4'b0000, 4'b0000, 0, 0, 16, 1, 0, 4'b0000};
        tbl[2] = '{"m1111",  4'b1111, 4'b1111, 4'b1111, 0, 0, 16, 1, 0, 4'b1111};
        tbl[3] = '{"mchg",   4'b0001, 4'b0011, 4'b0011, 0, 0, 24, 1, 0, 4'b0011};
        tbl[4] = '{"lane2ff",4'b0000, 4'b0000, 4'b0000, 1, 0, 64, 0, 1, 4'b0000};
        tbl[5] = '{"gap",    4'b0110, 4'b0110, 4'b0110, 0, 1, 16, 1, 0, 4'b0110};

        do_reset();
        chk("reset", {21'b0, out_data, out_valid, pol_mask, locked, train_err}, 32'd0);

        foreach (tbl[i]) begin
            do_reset();
            start_train();
            for (int b = 0; b < tbl[i].beats; b++) begin
                logic [3:0] mk;
                logic       bt;
                mk = (b < 8) ? tbl[i].m1 : (b < 16) ? tbl[i].m2 : tbl[i].m3;
                if (tbl[i].gap && b == 3) begin
                    in_valid = 1'b0;
                    for (int g = 0; g < 5; g++) step();
                end
                bt = pat[7 - (b % 8)];
                in_valid = 1'b1;
                in_data = {4{bt}} ^ mk;
                if (tbl[i].l2ff) in_data[2] = 1'b1;
                step();
                if (b == tbl[i].beats - 2)
                    chk({tbl[i].name, "_pre"}, {30'b0, locked, train_err}, 32'd0);
                if (b < tbl[i].beats - 1)
                    chk({tbl[i].name, "_ov"}, {31'b0, out_valid}, 32'd0);
            end
            in_valid = 1'b0;
            chk({tbl[i].name, "_stat"}, {26'b0, locked, train_err, pol_mask},
                {26'b0, tbl[i].e_lock, tbl[i].e_err, tbl[i].e_mask});
        end

        // Corrected traffic after lock, then hold when in_valid drops.
        do_reset();
        start_train();
        for (int b = 0; b < 16; b++) beat(b, 4'b1010);
        in_valid = 1'b1; in_data = 4'b1100;
        step();
        chk("corr_data", {27'b0, out_data, out_valid}, {27'b0, 4'b0110, 1'b1});
        in_valid = 1'b0; in_data = 4'b1111;
        step();
        chk("hold_data", {27'b0, out_data, out_valid}, {27'b0, 4'b0110, 1'b0});

        // Retrain: mask held during TRAIN, then mid-TRAIN reset restores defaults.
        start_train();
        for (int b = 0; b < 5; b++) beat(b, 4'b0101);
        chk("mask_held", {28'b0, pol_mask}, {28'b0, 4'b1010});
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_reset", {21'b0, out_data, out_valid, pol_mask, locked, train_err}, 32'd0);

        // Restart mid-window realigns; lock needs 16 beats after the restart.
        start_train();
        for (int b = 0; b < 4; b++) beat(b + 3, 4'b0101);
        start_train();
        for (int b = 0; b < 16; b++) begin
            beat(b, 4'b0101);
            if (b == 14) chk("restart_pre", {31'b0, locked}, 32'd0);
        end
        in_valid = 1'b0;
        chk("restart_lock", {27'b0, locked, pol_mask}, {27'b0, 1'b1, 4'b0101});

`ifdef LANE_POL_FORCE_EN
        do_reset();
        start_train();
        for (int b = 0; b < 3; b++) beat(b, 4'b0000);
        in_valid = 1'b0; force_en = 1'b1; force_mask = 4'b0101;
        step();
        force_en = 1'b0;
        chk("force", {27'b0, locked, pol_mask}, {27'b0, 1'b1, 4'b0101});
        force_en = 1'b1; train_start = 1'b1; force_mask = 4'b0011;
        step();
        force_en = 1'b0; train_start = 1'b0;
        chk("force_prio", {27'b0, locked, pol_mask}, {27'b0, 1'b1, 4'b0011});
`endif

        // Random traffic against the model.
        begin
            int         sb;
            logic [3:0] wm;
            sb = 0; wm = 4'b0;
            do_reset();
            for (int c = 0; c < 4000; c++) begin
                rst_n       = ($urandom_range(0, 599) != 0);
                train_start = ($urandom_range(0, 149) == 0);
                in_valid    = ($urandom_range(0, 3) != 0);
`ifdef LANE_POL_FORCE_EN
                force_en    = ($urandom_range(0, 399) == 0);
                force_mask  = 4'($urandom);
`endif
                if (train_start) sb = 0;
                if (in_valid && !train_start) begin
                    logic bt;
                    if (sb % 8 == 0 && $urandom_range(0, 9) < 3) wm = 4'($urandom);
                    bt = pat[7 - (sb % 8)];
                    in_data = {4{bt}} ^ wm;
                    if ($urandom_range(0, 59) == 0) in_data = in_data ^ 4'($urandom);
                    sb++;
                end else begin
                    in_data = 4'($urandom);
                end
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
